// File: rtl/alu_cmd_ctrl.sv
// Command controller for an external 4-bit combinational ALU.
// Accepts one command, runs one ALU cycle, then holds the result until consumed.
module alu_cmd_ctrl #(
  parameter logic [3:0] ACC_INIT = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic [3:0] alu_inA,
  output logic [3:0] alu_inB,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_ans,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic [3:0] acc
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic [3:0] acc_q, acc_d;

  logic accept;
  logic exec_done;

  assign accept    = (state_q == StIdle) && cmd_valid;
  assign exec_done = (state_q == StExec);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_valid) state_d = StExec;
      StExec: state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 2'b00;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      rsp_data_q <= 4'h0;
      acc_q      <= ACC_INIT;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      acc_q      <= acc_d;
    end
  end

  // The accumulator is sampled here at acceptance, so a command issued right
  // after a response already sees the value that response wrote.
  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    acc_d      = acc_q;
    if (accept) begin
      op_d = cmd_op;
      b_d  = cmd_b;
      a_d  = cmd_use_acc ? acc_q : cmd_a;
    end
    if (exec_done) begin
      rsp_data_d = alu_ans;
      acc_d      = alu_ans;
    end
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    alu_inA   = a_q;
    alu_inB   = b_q;
    alu_op    = op_q;
    rsp_data  = rsp_data_q;
    acc       = acc_q;
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: external ALU model, expected-result queue, scenario tasks.
module tb_alu_cmd_ctrl;

  localparam logic [3:0] AccInit = 4'h5;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;
  logic [3:0] alu_inA;
  logic [3:0] alu_inB;
  logic [1:0] alu_op;
  logic [3:0] alu_ans;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [3:0] acc;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] model_acc;
  logic       prev_valid = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.ACC_INIT(AccInit)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .alu_inA    (alu_inA),
    .alu_inB    (alu_inB),
    .alu_op     (alu_op),
    .alu_ans    (alu_ans),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .acc        (acc)
  );

  function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a,
                                      input logic [3:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a + b;
    endcase
  endfunction

  // External combinational ALU
  always_comb alu_ans = alu_f(alu_op, alu_inA, alu_inB);

  // Scoreboard: each new response (rising rsp_valid) pops one expected result
  always @(negedge clk) begin
    if (rsp_valid && !prev_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_rsp: got rsp_data=%h, required no response", rsp_data);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (rsp_data !== e) begin
          errors++;
          $display("FAIL sb_rsp_data: got %h, required %h", rsp_data, e);
        end
        checks++;
        if (acc !== e) begin
          errors++;
          $display("FAIL sb_acc: got %h, required %h", acc, e);
        end
      end
    end
    prev_valid = rsp_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer a command from the current negedge, wait for acceptance, check the
  // EXEC-cycle ALU inputs and the two-edge latency. Ends at the negedge in RESP.
  task automatic issue_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic ua);
    logic [3:0] ea;
    int n;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b, required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    ea = ua ? model_acc : a;
    exp_q.push_back(alu_f(op, ea, b));
    model_acc = alu_f(op, ea, b);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({alu_op, alu_inA, alu_inB, rsp_valid, cmd_ready} !== {op, ea, b, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL exec_inputs: got op=%b A=%h B=%h v=%b rdy=%b, required op=%b A=%h B=%h v=0 rdy=0",
               alu_op, alu_inA, alu_inB, rsp_valid, cmd_ready, op, ea, b);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: rsp_valid=%b two edges after accept, required 1", rsp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b11; cmd_a = 4'h7; cmd_b = 4'h7;
    cmd_use_acc = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, acc, alu_inA, alu_inB, alu_op} !==
        {1'b1, 1'b0, 4'h0, AccInit, 4'h0, 4'h0, 2'b00}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b v=%b d=%h acc=%h A=%h B=%h op=%b, required 1 0 0 %h 0 0 00",
               cmd_ready, rsp_valid, rsp_data, acc, alu_inA, alu_inB, alu_op, AccInit);
    end
    reset = 1'b0; cmd_valid = 1'b0;
    model_acc = AccInit;
    @(negedge clk);
  endtask

  task automatic test_add_wrap();
    rsp_ready = 1'b1;
    issue_cmd(2'b11, 4'h9, 4'h8, 1'b0);
    checks++;
    if (rsp_data !== 4'h1 || acc !== 4'h1) begin
      errors++;
      $display("FAIL add_9_8: got d=%h acc=%h, required 1 1", rsp_data, acc);
    end
    @(negedge clk);
    issue_cmd(2'b11, 4'hF, 4'h1, 1'b0);
    checks++;
    if (rsp_data !== 4'h0) begin
      errors++;
      $display("FAIL add_f_1: got %h, required 0", rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_chain();
    logic [3:0] want[3];
    logic [3:0] got[3];
    want[0] = 4'h7; want[1] = 4'hC; want[2] = 4'h3;
    rsp_ready = 1'b1;
    issue_cmd(2'b11, 4'h3, 4'h4, 1'b0);
    got[0] = rsp_data;
    @(negedge clk);
    issue_cmd(2'b11, 4'hE, 4'h5, 1'b1);
    got[1] = rsp_data;
    @(negedge clk);
    issue_cmd(2'b10, 4'h0, 4'hF, 1'b1);
    got[2] = rsp_data;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL chain_%0d: got %h, required %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_all_ops();
    logic [3:0] want[4];
    want[0] = 4'h8; want[1] = 4'hE; want[2] = 4'h6; want[3] = 4'h6;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_cmd(2'(i), 4'hC, 4'hA, 1'b0);
      checks++;
      if (rsp_data !== want[i]) begin
        errors++;
        $display("FAIL op_%0d: got %h, required %h", i, rsp_data, want[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue_cmd(2'b11, 4'h2, 4'h3, 1'b0);
    cmd_op = 2'b00; cmd_a = 4'h9; cmd_b = 4'h6; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready, rsp_data, acc, alu_inA, alu_op} !==
          {1'b1, 1'b0, 4'h5, 4'h5, 4'h2, 2'b11}) begin
        errors++;
        $display("FAIL hold_%0d: v=%b rdy=%b d=%h acc=%h A=%h op=%b, required 1 0 5 5 2 11",
                 i, rsp_valid, cmd_ready, rsp_data, acc, alu_inA, alu_op);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: rdy=%b v=%b, required 1 0", cmd_ready, rsp_valid);
    end
    issue_cmd(2'b00, 4'h9, 4'h6, 1'b0);
    checks++;
    if (rsp_data !== 4'h0) begin
      errors++;
      $display("FAIL after_release: got %h, required 0", rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int accepts;
    int first;
    int last;
    accepts = 0; first = -1; last = -1;
    rsp_ready = 1'b1;
    cmd_op = 2'b11; cmd_a = 4'h1; cmd_b = 4'h1; cmd_use_acc = 1'b1; cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (cmd_ready) begin
        exp_q.push_back(model_acc + 4'h1);
        model_acc = model_acc + 4'h1;
        if (first < 0) first = c;
        last = c;
        accepts++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (accepts !== 4 || last - first !== 9) begin
      errors++;
      $display("FAIL issue_interval: got %0d accepts span %0d, required 4 span 9",
               accepts, last - first);
    end
  endtask

  task automatic test_rsp_ready_idle();
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || acc !== model_acc) begin
      errors++;
      $display("FAIL idle_rsp_ready: v=%b rdy=%b acc=%h, required 0 1 %h",
               rsp_valid, cmd_ready, acc, model_acc);
    end
  endtask

  task automatic test_reset_mid_exec();
    rsp_ready = 1'b1;
    cmd_op = 2'b11; cmd_a = 4'hF; cmd_b = 4'h1; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, acc, alu_inA, alu_inB} !== {1'b1, 1'b0, AccInit, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_mid_exec: rdy=%b v=%b acc=%h A=%h B=%h, required 1 0 %h 0 0",
               cmd_ready, rsp_valid, acc, alu_inA, alu_inB, AccInit);
    end
    model_acc = AccInit;
    repeat (4) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || acc !== AccInit) begin
      errors++;
      $display("FAIL no_rsp_after_reset: v=%b acc=%h, required 0 %h", rsp_valid, acc, AccInit);
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_chain();
    test_all_ops();
    test_backpressure();
    test_back_to_back();
    test_rsp_ready_idle();
    test_reset_mid_exec();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
